// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory bus between the memory controller and the responder.
// master: mem_a/mem_dout/mem_wr out, mem_din/io_buffer_full in; slave mirrors it.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a,
        output mem_dout,
        output mem_wr,
        input  mem_din,
        input  io_buffer_full
    );

    modport slave (
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        output mem_din,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: synchronous byte RAM plus a UART window at 0x30000.
// Ports: clk_in, rst_in (sync, high), rdy_in, bus (slave), UART tx/rx, tx_overflow, sim_halt.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG2  = 3,
    parameter int FULL_MARGIN    = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    mem_io_responder_if.slave   bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                tx_overflow,
    output logic                sim_halt
);

    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int CW    = TX_DEPTH_LOG2 + 1;
    localparam int PW    = TX_DEPTH_LOG2;

    logic [7:0] ram [0:(1 << RAM_ADDR_WIDTH) - 1];
    logic [7:0] fifo [0:DEPTH - 1];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] free_nxt;

    logic [7:0] din_q;
    logic       full_q;
    logic [7:0] rx_hold;
    logic       rx_hold_valid;

    logic                      io_sel;
    logic [2:0]                off;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic                      push_req;
    logic                      push_ok;
    logic                      pop;
    logic                      fifo_full;
    logic                      rx_rd;
    logic                      halt_wr;
    logic                      unused_addr;

    assign io_sel      = (bus.mem_a[17:16] == 2'b11);
    assign off         = bus.mem_a[2:0];
    assign ram_addr    = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    assign unused_addr = ^bus.mem_a[31:18];

    assign push_req = rdy_in && io_sel && bus.mem_wr && (off == 3'd0);
    assign halt_wr  = rdy_in && io_sel && bus.mem_wr && (off == 3'd4);
    assign rx_rd    = rdy_in && io_sel && !bus.mem_wr && (off == 3'd0);

    assign tx_valid  = (count != '0);
    assign tx_data   = fifo[rptr];
    assign fifo_full = (count == CW'(DEPTH));
    assign pop       = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok   = push_req && (!fifo_full || pop);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push_ok && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    assign free_nxt = CW'(DEPTH) - count_nxt;

    assign bus.mem_din        = din_q;
    assign bus.io_buffer_full = full_q;

    // RAM and FIFO storage carry no reset so they map onto block memory.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !io_sel && bus.mem_wr) begin
            ram[ram_addr] <= bus.mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            fifo[wptr] <= bus.mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            full_q      <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count  <= count_nxt;
            // Registered flag: the margin absorbs the access already in flight.
            full_q <= (free_nxt <= CW'(FULL_MARGIN));
            if (push_req && !push_ok) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_hold       <= 8'h00;
            rx_hold_valid <= 1'b0;
            sim_halt      <= 1'b0;
        end else begin
            // A new byte wins over a same-cycle read; the read still
            // returns the old byte through din_q below.
            if (rx_valid) begin
                rx_hold       <= rx_data;
                rx_hold_valid <= 1'b1;
            end else if (rx_rd) begin
                rx_hold_valid <= 1'b0;
            end
            if (halt_wr) begin
                sim_halt <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            din_q <= 8'h00;
        end else if (rdy_in && !bus.mem_wr) begin
            if (!io_sel) begin
                din_q <= ram[ram_addr];
            end else begin
                unique case (off)
                    3'd0:    din_q <= rx_hold_valid ? rx_hold : 8'h00;
                    3'd4:    din_q <= {5'b0, full_q, tx_valid, rx_hold_valid};
                    default: din_q <= 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
// One task per scenario; each task checks its own expected values inline.
module tb_mem_io_responder;

    logic       clk_in;
    logic       rst_in;
    logic       rdy_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_overflow;
    logic       sim_halt;

    int n_checks;
    int n_fail;

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .bus         (bus),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_overflow (tx_overflow),
        .sim_halt    (sim_halt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.mem_a    = 32'h0;
        bus.mem_dout = 8'h00;
        bus.mem_wr   = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
        bus.mem_a    = a;
        bus.mem_dout = d;
        bus.mem_wr   = 1'b1;
        tick();
        idle();
    endtask

    task automatic bus_rd(input logic [31:0] a);
        bus.mem_a  = a;
        bus.mem_wr = 1'b0;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.mem_din !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_din: got %h want 00", bus.mem_din);
        end
        n_checks++;
        if ({tx_valid, bus.io_buffer_full, tx_overflow, sim_halt} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_flags: got %b want 0000",
                     {tx_valid, bus.io_buffer_full, tx_overflow, sim_halt});
        end
        rst_in = 1'b0;
        // Known value at the idle address so idle reads are predictable.
        bus_wr(32'h0, 8'h00);
        tick();
    endtask

    task automatic test_ram_rw();
        bus_wr(32'h10, 8'hA5);
        n_checks++;
        if (bus.mem_din !== 8'h00) begin
            n_fail++;
            $display("FAIL ram_wr_hold: got %h want 00", bus.mem_din);
        end
        bus_rd(32'h10);
        n_checks++;
        if (bus.mem_din !== 8'hA5) begin
            n_fail++;
            $display("FAIL ram_rd: got %h want a5", bus.mem_din);
        end
        bus_wr(32'h1FFFF, 8'h3C);
        bus_wr(32'h20, 8'h11);
        bus_rd(32'h1FFFF);
        n_checks++;
        if (bus.mem_din !== 8'h3C) begin
            n_fail++;
            $display("FAIL ram_rd_top: got %h want 3c", bus.mem_din);
        end
        bus_rd(32'h20);
        n_checks++;
        if (bus.mem_din !== 8'h11) begin
            n_fail++;
            $display("FAIL ram_rd_20: got %h want 11", bus.mem_din);
        end
    endtask

    task automatic test_tx_fill_overflow();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus_wr(32'h30000, 8'(8'h41 + i));
            if (i == 4) begin
                n_checks++;
                if (bus.io_buffer_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ibf_5: got %b want 0", bus.io_buffer_full);
                end
            end
        end
        n_checks++;
        if (bus.io_buffer_full !== 1'b1) begin
            n_fail++;
            $display("FAIL ibf_6: got %b want 1", bus.io_buffer_full);
        end
        bus_wr(32'h30000, 8'h47);
        bus_wr(32'h30000, 8'h48);
        n_checks++;
        if (tx_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_8: got %b want 0", tx_overflow);
        end
        bus_wr(32'h30000, 8'h49);
        n_checks++;
        if (tx_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_9: got %b want 1", tx_overflow);
        end
        bus_rd(32'h30004);
        n_checks++;
        if (bus.mem_din !== 8'h06) begin
            n_fail++;
            $display("FAIL status_full: got %h want 06", bus.mem_din);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                n_fail++;
                $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h",
                         i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            tick();
        end
        tx_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0 || bus.io_buffer_full !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_end: got v=%b ibf=%b want 0 0",
                     tx_valid, bus.io_buffer_full);
        end
    endtask

    task automatic test_tx_drain();
        do_reset();
        tx_ready = 1'b0;
        bus_wr(32'h30000, 8'h41);
        bus_wr(32'h30000, 8'h42);
        bus_wr(32'h30000, 8'h43);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
                n_fail++;
                $display("FAIL pop_%0d: got v=%b d=%h want v=1 d=%h",
                         i, tx_valid, tx_data, 8'(8'h41 + i));
            end
            tick();
        end
        tx_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_empty: got %b want 0", tx_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [$];
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_wr(32'h30000, 8'(8'h10 + i));
        end
        n_checks++;
        if (tx_data !== 8'h10 || bus.io_buffer_full !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_pre: got d=%h ibf=%b want 10 1",
                     tx_data, bus.io_buffer_full);
        end
        tx_ready = 1'b1;
        bus_wr(32'h30000, 8'h99);
        tx_ready = 1'b0;
        n_checks++;
        if (tx_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_ovf: got %b want 0", tx_overflow);
        end
        for (int i = 1; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
        exp_q.push_back(8'h99);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL pp_drain_%0d: got v=%b d=%h want v=1 d=%h",
                         i, tx_valid, tx_data, exp_q[i]);
            end
            tick();
        end
        tx_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_empty: got %b want 0", tx_valid);
        end
    endtask

    task automatic test_rx();
        do_reset();
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        bus_rd(32'h30004);
        n_checks++;
        if (bus.mem_din !== 8'h01) begin
            n_fail++;
            $display("FAIL rx_stat1: got %h want 01", bus.mem_din);
        end
        bus_rd(32'h30000);
        n_checks++;
        if (bus.mem_din !== 8'h5A) begin
            n_fail++;
            $display("FAIL rx_rd1: got %h want 5a", bus.mem_din);
        end
        bus_rd(32'h30004);
        n_checks++;
        if (bus.mem_din !== 8'h00) begin
            n_fail++;
            $display("FAIL rx_stat2: got %h want 00", bus.mem_din);
        end
        bus_rd(32'h30000);
        n_checks++;
        if (bus.mem_din !== 8'h00) begin
            n_fail++;
            $display("FAIL rx_rd_empty: got %h want 00", bus.mem_din);
        end
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        tick();
        rx_data = 8'h22;
        bus_rd(32'h30000);
        rx_valid = 1'b0;
        n_checks++;
        if (bus.mem_din !== 8'h11) begin
            n_fail++;
            $display("FAIL rx_race_old: got %h want 11", bus.mem_din);
        end
        bus_rd(32'h30000);
        n_checks++;
        if (bus.mem_din !== 8'h22) begin
            n_fail++;
            $display("FAIL rx_race_new: got %h want 22", bus.mem_din);
        end
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        tick();
        rx_data = 8'h44;
        tick();
        rx_valid = 1'b0;
        bus_rd(32'h30000);
        n_checks++;
        if (bus.mem_din !== 8'h44) begin
            n_fail++;
            $display("FAIL rx_overwrite: got %h want 44", bus.mem_din);
        end
        bus_rd(32'h30002);
        n_checks++;
        if (bus.mem_din !== 8'h00) begin
            n_fail++;
            $display("FAIL io_other: got %h want 00", bus.mem_din);
        end
    endtask

    task automatic test_halt_rdy_reset();
        do_reset();
        n_checks++;
        if (sim_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_pre: got %b want 0", sim_halt);
        end
        bus_wr(32'h30004, 8'h00);
        n_checks++;
        if (sim_halt !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_set: got %b want 1", sim_halt);
        end
        bus_rd(32'h20);
        rdy_in = 1'b0;
        bus_wr(32'h20, 8'h77);
        bus_rd(32'h10);
        n_checks++;
        if (bus.mem_din !== 8'h11) begin
            n_fail++;
            $display("FAIL rdy_hold_din: got %h want 11", bus.mem_din);
        end
        rdy_in = 1'b1;
        bus_rd(32'h20);
        n_checks++;
        if (bus.mem_din !== 8'h11) begin
            n_fail++;
            $display("FAIL rdy_no_wr: got %h want 11", bus.mem_din);
        end
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_wr(32'h30000, 8'(8'h60 + i));
        end
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if ({tx_valid, bus.io_buffer_full, tx_overflow} !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_rst: got %b want 111",
                     {tx_valid, bus.io_buffer_full, tx_overflow});
        end
        do_reset();
        n_checks++;
        if ({tx_valid, bus.io_buffer_full, tx_overflow, sim_halt} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_rst_flags: got %b want 0000",
                     {tx_valid, bus.io_buffer_full, tx_overflow, sim_halt});
        end
        bus_rd(32'h30004);
        n_checks++;
        if (bus.mem_din !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_rst_stat: got %h want 00", bus.mem_din);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle();
        test_reset();
        test_ram_rw();
        test_tx_fill_overflow();
        test_tx_drain();
        test_full_push_pop();
        test_rx();
        test_halt_rdy_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

endmodule
